// File: rtl/reset_sequencer.sv
// Staged reset-release controller: enables per-domain reset synchronizers in order 0..NUM_DOMAINS-1,
// waiting for each domain's ready and a programmable gap. `define RSTSEQ_TIMEOUT_EN adds a WAIT_RDY timeout.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int DELAY_W        = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic [DELAY_W-1:0]     cfg_delay,
  input  logic [NUM_DOMAINS-1:0] domain_rdy,
  output logic [NUM_DOMAINS-1:0] rst_en,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err
);

  localparam int CNT_MAX_A = (HOLD_CYCLES > (2 ** DELAY_W)) ? HOLD_CYCLES : (2 ** DELAY_W);
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_RELEASE, S_WAIT_RDY, S_GAP, S_DONE, S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] rdy_meta_q, rdy_meta_d;
  logic [NUM_DOMAINS-1:0] rdy_s_q, rdy_s_d;
  logic [NUM_DOMAINS-1:0] rst_en_q, rst_en_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DELAY_W-1:0]     delay_q, delay_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef RSTSEQ_TIMEOUT_EN
  logic                   err_q, err_d;
`endif

  always_comb begin
    // NOTE: every _d starts from its held value, so no path through the case below can infer a latch.
    state_d    = state_q;
    rst_en_d   = rst_en_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    delay_d    = delay_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef RSTSEQ_TIMEOUT_EN
    err_d      = err_q;
`endif
    rdy_meta_d = domain_rdy;
    rdy_s_d    = rdy_meta_q;

    // A software restart beats every other transition, including a same-cycle ready.
    if (sw_rst_req) begin
      state_d  = S_HOLD;
      rst_en_d = '0;
      idx_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
      err_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          rst_en_d[idx_q] = 1'b1;
          cnt_d           = '0;
          state_d         = S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (rdy_s_q[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d  = S_DONE;
              rst_en_d = '1;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              delay_d = cfg_delay;
              cnt_d   = '0;
              state_d = S_GAP;
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (cnt_q >= CNT_W'(delay_q)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          rst_en_d = '1;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HOLD;
      rst_en_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      delay_q    <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      rdy_meta_q <= '0;
      rdy_s_q    <= '0;
`ifdef RSTSEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rst_en_q   <= rst_en_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_meta_q <= rdy_meta_d;
      rdy_s_q    <= rdy_s_d;
`ifdef RSTSEQ_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign rst_en   = rst_en_q;
  assign seq_busy = busy_q;
  assign seq_done = done_q;
`ifdef RSTSEQ_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: the driver predicts when each output change must appear,
// and a negedge monitor pops and compares every change the DUT actually presents.
module tb_reset_sequencer;

  localparam int ND   = 4;
  localparam int HOLD = 8;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  localparam int ABORT_NONE = 0;
  localparam int ABORT_SW   = 1;
  localparam int ABORT_RST  = 2;
  localparam int ABORT_TMO  = 3;

  typedef struct {
    int            edge_no;
    logic [ND+2:0] outs;
  } ev_t;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic [DW-1:0] cfg_delay  = '0;
  logic [ND-1:0] domain_rdy = '0;
  logic [ND-1:0] rst_en;
  logic          seq_busy, seq_done, timeout_err;

  ev_t           sb_q[$];
  int            edge_cnt = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            mon_en   = 1'b0;
  logic [ND+2:0] last_outs;
  logic [ND+2:0] mon_cur;
  ev_t           mon_ev;

  reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .HOLD_CYCLES   (HOLD),
    .DELAY_W       (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .cfg_delay  (cfg_delay),
    .domain_rdy (domain_rdy),
    .rst_en     (rst_en),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [ND+2:0] pack(input logic [ND-1:0] en, input logic busy,
                                         input logic done, input logic err);
    return {en, busy, done, err};
  endfunction

  // Thermometer code with bits 0..k set.
  function automatic logic [ND-1:0] therm(input int k);
    logic [ND-1:0] v;
    v = '0;
    for (int b = 0; b < ND; b++) if (b <= k) v[b] = 1'b1;
    return v;
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(3, 0) == 0) return int'($urandom_range(40, 8));
    return int'($urandom_range(7, 0));
  endfunction

  task automatic push(input int e, input logic [ND-1:0] en, input logic busy,
                      input logic done, input logic err);
    ev_t ev;
    ev.edge_no = e;
    ev.outs    = pack(en, busy, done, err);
    sb_q.push_back(ev);
  endtask

  // Advance to #1 after posedge number n.
  task automatic step_to(input int n);
    while (edge_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse sw_rst_req so it is sampled on the next edge; returns the first HOLD-counting edge after it.
  task automatic sw_issue(output int f_next);
    int s;
    s = edge_cnt + 1;
    push(s, '0, 1'b1, 1'b0, 1'b0);
    sw_rst_req = 1'b1;
    domain_rdy = '0;
    step_to(s);
    sw_rst_req = 1'b0;
    f_next     = s + 1;
  endtask

  task automatic sw_in_done(output int f_next);
    for (int j = 0; j < 8; j++) begin
      step_to(edge_cnt + 1);
      domain_rdy = ND'($urandom);
    end
    sw_issue(f_next);
  endtask

  // One sequence starting with HOLD count 0 at edge f. Timing rules:
  //   rst_en[0] appears after edge f+HOLD; domain_rdy raised after edge k is seen at edge k+3;
  //   seen at e -> next rst_en bit after edge e+d+2 (d = cfg_delay at e), or DONE after edge e.
  task automatic run_seq(input int f, input int lag_fix, input int dly_fix,
                         input int abort_mode, output int f_next);
    int r, k, e, d, lag;
    f_next = -1;
    r = f + HOLD;
    push(r, therm(0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ND; i++) begin
`ifdef RSTSEQ_TIMEOUT_EN
      if (abort_mode == ABORT_TMO && i == 2) begin
        push(r + TMO, therm(2), 1'b0, 1'b0, 1'b1);
        step_to(r + TMO + 2);
        sw_issue(f_next);
        return;
      end
`endif
      lag = (lag_fix >= 0) ? lag_fix : int'($urandom_range(5, 0));
      k   = r + lag;
      step_to(k);
      domain_rdy[i] = 1'b1;
      cfg_delay     = DW'($urandom);
      e = k + 3;
      d = (dly_fix >= 0) ? dly_fix : rand_delay();
      step_to(e - 1);
      cfg_delay = DW'(d);
      if (abort_mode == ABORT_SW && i == 1) begin
        sw_issue(f_next);
        return;
      end
      if (i == ND - 1) begin
        push(e, '1, 1'b0, 1'b1, 1'b0);
      end else if (abort_mode == ABORT_RST && i == 0) begin
        push(e + 2, '0, 1'b1, 1'b0, 1'b0);
      end else begin
        r = e + d + 2;
        push(r, therm(i + 1), 1'b1, 1'b0, 1'b0);
      end
      step_to(e);
      cfg_delay = DW'($urandom);
      if (abort_mode == ABORT_RST && i == 0) begin
        step_to(e + 1);
        rst        = 1'b1;
        domain_rdy = '0;
        step_to(e + 2);
        rst    = 1'b0;
        f_next = e + 3;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = pack(rst_en, seq_busy, seq_done, timeout_err);
      check("rst_en_thermometer", 64'((rst_en & (rst_en + 1'b1)) == '0), 64'd1);
      if (mon_cur !== last_outs) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: edge %0d outputs %b, no change expected", edge_cnt, mon_cur);
        end else begin
          mon_ev = sb_q.pop_front();
          check("event_edge", 64'(edge_cnt), 64'(mon_ev.edge_no));
          check("event_outputs", 64'(mon_cur), 64'(mon_ev.outs));
        end
        last_outs = mon_cur;
      end
    end
  end

  initial begin
    int f;
    int unused_f;
    step_to(3);
    check("reset_rst_en", 64'(rst_en), 64'd0);
    check("reset_seq_busy", 64'(seq_busy), 64'd1);
    check("reset_seq_done", 64'(seq_done), 64'd0);
    check("reset_timeout_err", 64'(timeout_err), 64'd0);
    last_outs = pack('0, 1'b1, 1'b0, 1'b0);
    mon_en    = 1'b1;
    rst       = 1'b0;
    f         = 4;

    // Echo after 4 cycles with a gap of 3, then the identical run again after a restart in DONE.
    run_seq(f, 4, 3, ABORT_NONE, unused_f);
    sw_in_done(f);
    run_seq(f, 4, 3, ABORT_NONE, unused_f);
    sw_in_done(f);

    // Zero gap.
    run_seq(f, -1, 0, ABORT_NONE, unused_f);
    sw_in_done(f);

    // Restart colliding with domain 1 ready, then rst in the middle of a gap.
    run_seq(f, -1, -1, ABORT_SW, f);
    run_seq(f, -1, 4, ABORT_RST, f);

    for (int n = 0; n < 6; n++) begin
      run_seq(f, -1, -1, ABORT_NONE, unused_f);
      sw_in_done(f);
    end

`ifdef RSTSEQ_TIMEOUT_EN
    run_seq(f, -1, -1, ABORT_TMO, f);
`endif
    run_seq(f, -1, -1, ABORT_NONE, unused_f);

    step_to(edge_cnt + 20);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
